// File: rtl/gpio_arb_seq_if.sv
// gpio_arb_seq_if: AHB-Lite bus between the gpio_arb_seq sequencer and the GPIO slave.
interface gpio_arb_seq_if;
    logic        HSEL;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        PARITYERR;
    modport master (
        output HSEL, HWRITE, HTRANS, HADDR, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, PARITYERR
    );
    modport slave (
        input  HSEL, HWRITE, HTRANS, HADDR, HWDATA, HREADY,
        output HREADYOUT, HRDATA, PARITYERR
    );
endinterface

// File: rtl/gpio_arb_seq.sv
// gpio_arb_seq: round-robin arbiter for two requesters issuing single AHB-Lite transfers to a GPIO slave.
// Define GPIO_ARB_PARITY_CHK_EN to flag slave parity errors on reads and expose PERR_CNT.
module gpio_arb_seq #(
    parameter logic [31:0] BASE_ADDR = 32'h5300_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WR0,
    input  logic        WR1,
    input  logic [7:0]  OFS0,
    input  logic [7:0]  OFS1,
    input  logic [31:0] WDATA0,
    input  logic [31:0] WDATA1,
    output logic        ACK0,
    output logic        ACK1,
    output logic [31:0] RDATA,
    output logic        ERR,
`ifdef GPIO_ARB_PARITY_CHK_EN
    output logic [15:0] PERR_CNT,
`endif
    gpio_arb_seq_if.master ahb
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t      state;
    logic        ptr, gnt, pick, pe, expired;
    logic [7:0]  wcnt, ofs_pick;
    logic [31:0] wdata_l;
    // ptr holds the last grant, so a tie goes to the other requester
    assign pick = (REQ0 && REQ1) ? ~ptr : REQ1;
    assign ofs_pick = pick ? OFS1 : OFS0;
    assign expired = !ahb.HREADYOUT && (wcnt == 8'(TIMEOUT - 1));
    assign ahb.HREADY = (state == DATA) ? ahb.HREADYOUT : 1'b1;
`ifdef GPIO_ARB_PARITY_CHK_EN
    assign pe = ahb.PARITYERR && !ahb.HWRITE;
`else
    logic unused_parity;
    assign unused_parity = ahb.PARITYERR;
    assign pe = 1'b0;
`endif
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            ptr        <= 1'b1;
            gnt        <= 1'b0;
            wcnt       <= '0;
            wdata_l    <= '0;
            ahb.HSEL   <= 1'b0;
            ahb.HTRANS <= 2'b00;
            ahb.HWRITE <= 1'b0;
            ahb.HADDR  <= '0;
            ahb.HWDATA <= '0;
            ACK0       <= 1'b0;
            ACK1       <= 1'b0;
            ERR        <= 1'b0;
            RDATA      <= '0;
`ifdef GPIO_ARB_PARITY_CHK_EN
            PERR_CNT   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (REQ0 || REQ1) begin
                    state      <= ADDR;
                    gnt        <= pick;
                    ptr        <= pick;
                    wdata_l    <= pick ? WDATA1 : WDATA0;
                    ahb.HSEL   <= 1'b1;
                    ahb.HTRANS <= 2'b10;
                    ahb.HWRITE <= pick ? WR1 : WR0;
                    ahb.HADDR  <= {BASE_ADDR[31:8], ofs_pick & 8'hfc};
                end
                ADDR: begin
                    state      <= DATA;
                    wcnt       <= '0;
                    ahb.HSEL   <= 1'b0;
                    ahb.HTRANS <= 2'b00;
                    ahb.HWDATA <= wdata_l;
                end
                DATA: begin
                    wcnt <= ahb.HREADYOUT ? wcnt : wcnt + 8'd1;
                    if (ahb.HREADYOUT || expired) begin
                        state <= RESP;
                        ACK0  <= !gnt;
                        ACK1  <= gnt;
                        ERR   <= expired || pe;
                        RDATA <= expired ? '0 : ahb.HWRITE ? RDATA : ahb.HRDATA;
`ifdef GPIO_ARB_PARITY_CHK_EN
                        if (ahb.HREADYOUT && pe && PERR_CNT != 16'hffff) PERR_CNT <= PERR_CNT + 16'd1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    ACK0  <= 1'b0;
                    ACK1  <= 1'b0;
                    ERR   <= 1'b0;
                end
            endcase
        end
    end
endmodule
